spi_mem_bridge: RTL and testbench
=================================

// Module: spi_mem_bridge
// PURPOSE
// - Command-driven bridge between the SPI byte stream (spi_receiver data/strobe) and the program latch memory.
// - Parametrised successor to the single-purpose SPI write path: it adds configurable address and data width,
//   explicit address load, memory read-back over MISO, a status byte, and unknown-opcode rejection.
// - Sits between spi_receiver and latch_mem. The top level muxes its memory port against the CPU port using cpu_hold_o.
// PARAMETERS
// - ADDR_WIDTH  6  memory word address width; ADDR_BYTES = ceil(ADDR_WIDTH/8)
// - DATA_WIDTH  8  memory word width, one of 8/16/32; DATA_BYTES = DATA_WIDTH/8
// PORTS
// - clk_i        in   1           system clock
// - rst_i        in   1           asynchronous reset, active-high
// - enable_i     in   1           synchronised mode; 1 = bridge owns memory
// - frame_i      in   1           synchronised SPI chip-select, 1 = frame active
// - rx_data_i    in   8           received byte
// - rx_stb_i     in   1           one-cycle strobe, rx_data_i valid
// - tx_data_o    out  8           byte shifted out during the next SPI byte
// - mem_addr_o   out  ADDR_WIDTH  memory address
// - mem_wdata_o  out  DATA_WIDTH  memory write data
// - mem_we_o     out  1           one-cycle write enable
// - mem_rdata_i  in   DATA_WIDTH  combinational read data at mem_addr_o
// - cpu_hold_o   out  1           hold CPU in reset; equals enable_i
// BEHAVIOUR
// - Reset (rst_i=1): state IDLE; tx_data_o=0, mem_addr_o=0, mem_wdata_o=0, mem_we_o=0, status=0.
// - Frame format: opcode byte, then ADDR_BYTES address bytes MSB first (bits above ADDR_WIDTH ignored), then payload.
// - Opcodes: 0x01 WRITE, 0x02 READ, 0x05 STATUS. Any other value: status.bad_op=1, state IGNORE until frame end.
// - FSM states: IDLE, ADDR, WRITE, RD_FETCH, READ, IGNORE.
// - IDLE: first rx_stb_i of a frame captures the opcode. WRITE/READ -> ADDR. STATUS -> IGNORE with tx_data_o=status.
// - ADDR: counts ADDR_BYTES strobes, shifting bytes into mem_addr_o. On the last byte: WRITE -> WRITE, READ -> RD_FETCH.
// - WRITE: bytes shift MSB first into mem_wdata_o.
//   - After DATA_BYTES strobes, mem_we_o=1 in the following cycle (latency 1 clk).
//   - mem_addr_o increments in the cycle after the write pulse; status.wr_cnt (4b, saturating) increments.
// - RD_FETCH: one cycle. Latch mem_rdata_i into the read shift register and set tx_data_o = MS byte -> READ.
//   - tx_data_o is therefore valid 2 clk after the last address strobe, well inside one SPI byte time.
// - READ: each rx_stb_i (byte content ignored) advances tx_data_o to the next byte.
//   - After DATA_BYTES strobes, mem_addr_o increments and the FSM returns to RD_FETCH.
// - Address wrap: 2^ADDR_WIDTH-1 + 1 -> 0 and status.wrap=1 (sticky until a STATUS read).
// - status byte = {bad_op, wrap, 2'b0, wr_cnt}. A completed STATUS frame clears bad_op, wrap and wr_cnt.
// - Frame end (frame_i 1->0): all states return to IDLE next clk.
//   - A partially assembled write word is discarded with no mem_we_o.
//   - mem_addr_o is retained.
// - rx_stb_i in the same cycle as frame_i=0: the byte is dropped; frame end wins.
// - enable_i=0: FSM forced to IDLE, mem_we_o=0, rx_stb_i ignored, tx_data_o=0.
//   - enable_i 0->1 clears mem_addr_o to 0.
// - rst_i mid-frame: immediate return to reset values; no partial write is ever issued.
// - mem_we_o is never asserted outside WRITE and never for two consecutive cycles.
// STRUCTURE
// - Shared package dig_ctrl_pkg:
//   - opcode_t enum (OP_WRITE=8'h01, OP_READ=8'h02, OP_STATUS=8'h05).
//   - bridge_state_t enum.
//   - status_t packed struct.
// - Sub-module word_shift #(DATA_WIDTH): byte-wide shift register with load/shift-in/shift-out.
//   - One instance assembles write words; a second instance serialises read words.
// - The byte counter is sized $clog2(max(ADDR_BYTES,DATA_BYTES))+1.
// TESTING
// - WRITE, DATA_WIDTH=8, ADDR_WIDTH=6: bytes 01,00,AA,55.
//   -> two mem_we_o pulses: addr0=AA, addr1=55; mem_addr_o ends at 2.
// - WRITE, DATA_WIDTH=16: 01,3F,12,34,56,78.
//   -> addr 3F=1234, addr 00=5678; status.wrap=1.
// - READ, DATA_WIDTH=16, mem[5]=BEEF: 02,05,xx,xx,xx.
//   -> tx_data_o BE, EF, then mem[6] MS byte; no mem_we_o.
// - Opcode 0x7E then 3 bytes -> no writes. Then STATUS frame 05,xx -> tx 0x80; a second STATUS frame returns 0x00.
// - WRITE frame 01,00,11 with DATA_WIDTH=16 and frame_i dropped -> no mem_we_o. rx_stb_i coincident with frame_i=0 -> ignored.
// - rst_i during WRITE payload -> all outputs 0 next cycle. enable_i toggle mid-frame -> IDLE, mem_addr_o=0.

Source files
------------

// File: rtl/dig_ctrl_pkg.sv
// Shared types for the SPI-to-memory bridge: opcodes, FSM states and the status byte layout.
package dig_ctrl_pkg;

  typedef enum logic [7:0] {
    OP_WRITE  = 8'h01,
    OP_READ   = 8'h02,
    OP_STATUS = 8'h05
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_WRITE    = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_READ     = 3'd4,
    ST_IGNORE   = 3'd5
  } bridge_state_t;

  typedef struct packed {
    logic       bad_op;
    logic       wrap;
    logic [1:0] rsvd;
    logic [3:0] wr_cnt;
  } status_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_valid_op(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ) || (op == OP_STATUS);
  endfunction

endpackage

// File: rtl/word_shift.sv
// Byte-wide shift register: parallel load, or shift one byte in at the LS end (MS byte falls out).
module word_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_word,
  input  logic         shift,
  input  logic [7:0]   in_byte,
  output logic [W-1:0] word
);

  logic [W-1:0] shifted_s;

  generate
    if (W > 8) begin : g_wide
      assign shifted_s = {word[W-9:0], in_byte};
    end else begin : g_byte
      assign shifted_s = in_byte;
    end
  endgenerate

  // Word register: load has priority over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (load) begin
      word <= load_word;
    end else if (shift) begin
      word <= shifted_s;
    end else begin
      word <= word;
    end
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// Command-driven bridge from the SPI byte stream to the program latch memory:
// write, read-back and status opcodes with a parametrised address/data width.
module spi_mem_bridge
  import dig_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  frame_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_stb_i,
  output logic [7:0]            tx_data_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  cpu_hold_o
);

  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W      = $clog2(max_int(ADDR_BYTES, DATA_BYTES)) + 1;
  localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

  bridge_state_t         state_r, next_state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  op_read_r, status_frame_r, enable_prev_r, we_r;
  status_t               status_r;
  logic [ADDR_WIDTH-1:0] addr_r, addr_shift_val_s;
  logic [7:0]            tx_r;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic op_cap_s, addr_shift_s, wr_shift_s, wr_done_s, fetch_s, rd_adv_s, rd_done_s;
  logic cnt_inc_s, status_clr_s, addr_clr_s, addr_inc_s;

  generate
    if (ADDR_WIDTH > 8) begin : g_addr_wide
      assign addr_shift_val_s = {addr_r[ADDR_WIDTH-9:0], rx_data_i};
    end else begin : g_addr_byte
      assign addr_shift_val_s = rx_data_i[ADDR_WIDTH-1:0];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; losing the frame or the enable always wins.
  always_comb begin
    next_state_s = state_r;
    if (!enable_i || !frame_i) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rx_stb_i) begin
            if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
              next_state_s = ST_ADDR;
            end else begin
              next_state_s = ST_IGNORE;
            end
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (rx_stb_i && cnt_r == ADDR_LAST) begin
            next_state_s = op_read_r ? ST_RD_FETCH : ST_WRITE;
          end else begin
            next_state_s = ST_ADDR;
          end
        end
        ST_WRITE:    next_state_s = ST_WRITE;
        ST_RD_FETCH: next_state_s = ST_READ;
        ST_READ: begin
          if (rx_stb_i && cnt_r == DATA_LAST) begin
            next_state_s = ST_RD_FETCH;
          end else begin
            next_state_s = ST_READ;
          end
        end
        ST_IGNORE:   next_state_s = ST_IGNORE;
        default:     next_state_s = ST_IDLE;
      endcase
    end
  end

  // Per-cycle datapath controls decoded from state and strobe.
  always_comb begin
    op_cap_s     = 1'b0;
    addr_shift_s = 1'b0;
    wr_shift_s   = 1'b0;
    wr_done_s    = 1'b0;
    rd_adv_s     = 1'b0;
    rd_done_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    if (enable_i && frame_i && rx_stb_i) begin
      case (state_r)
        ST_IDLE: op_cap_s = 1'b1;
        ST_ADDR: begin
          addr_shift_s = 1'b1;
          cnt_inc_s    = 1'b1;
        end
        ST_WRITE: begin
          wr_shift_s = 1'b1;
          if (cnt_r == DATA_LAST) begin
            wr_done_s = 1'b1;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end
        ST_READ: begin
          cnt_inc_s = 1'b1;
          if (cnt_r == DATA_LAST) begin
            rd_done_s = 1'b1;
          end else begin
            rd_adv_s = 1'b1;
          end
        end
        default: op_cap_s = 1'b0;
      endcase
    end else begin
      op_cap_s = 1'b0;
    end
    fetch_s      = enable_i && frame_i && (state_r == ST_RD_FETCH);
    status_clr_s = enable_i && !frame_i && (state_r == ST_IGNORE) && status_frame_r;
    addr_clr_s   = enable_i && !enable_prev_r;
    addr_inc_s   = (we_r || rd_done_s) && !addr_clr_s;
  end

  // Byte counter, cleared on every state change and after each completed write word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (next_state_s != state_r || wr_done_s) begin
      cnt_r <= '0;
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered outputs, opcode flags and status byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable_prev_r  <= 1'b0;
      we_r           <= 1'b0;
      op_read_r      <= 1'b0;
      status_frame_r <= 1'b0;
      addr_r         <= '0;
      tx_r           <= 8'h00;
      status_r       <= '0;
    end else begin
      enable_prev_r <= enable_i;
      we_r          <= wr_done_s;
      if (op_cap_s) begin
        op_read_r      <= (rx_data_i == OP_READ);
        status_frame_r <= (rx_data_i == OP_STATUS);
      end
      if (addr_clr_s) begin
        addr_r <= '0;
      end else if (addr_shift_s) begin
        addr_r <= addr_shift_val_s;
      end else if (addr_inc_s) begin
        addr_r <= addr_r + ADDR_WIDTH'(1);
      end
      if (!enable_i) begin
        tx_r <= 8'h00;
      end else if (op_cap_s && rx_data_i == OP_STATUS) begin
        tx_r <= status_r;
      end else if (fetch_s) begin
        tx_r <= mem_rdata_i[DATA_WIDTH-1 -: 8];
      end else if (rd_adv_s) begin
        tx_r <= rd_word_s[DATA_WIDTH-1 -: 8];
      end
      if (status_clr_s) begin
        status_r.bad_op <= 1'b0;
        status_r.wrap   <= 1'b0;
        status_r.wr_cnt <= 4'd0;
      end else begin
        if (op_cap_s && !is_valid_op(rx_data_i)) status_r.bad_op <= 1'b1;
        if (addr_inc_s && addr_r == ADDR_MAX) status_r.wrap <= 1'b1;
        if (we_r && status_r.wr_cnt != 4'hF) status_r.wr_cnt <= status_r.wr_cnt + 4'd1;
      end
    end
  end

  word_shift #(.W(DATA_WIDTH)) u_wr_shift (
    .clk(clk_i), .rst(rst_i), .load(1'b0), .load_word('0),
    .shift(wr_shift_s), .in_byte(rx_data_i), .word(mem_wdata_o)
  );

  // Read word is stored pre-shifted: its MS byte is always the next byte to send.
  word_shift #(.W(DATA_WIDTH)) u_rd_shift (
    .clk(clk_i), .rst(rst_i), .load(fetch_s), .load_word(mem_rdata_i << 8),
    .shift(rd_adv_s), .in_byte(8'h00), .word(rd_word_s)
  );

  assign tx_data_o  = tx_r;
  assign mem_addr_o = addr_r;
  assign mem_we_o   = we_r;
  assign cpu_hold_o = enable_i;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench: an 8-bit and a 16-bit bridge share one SPI stimulus stream, each with its own memory model.
module tb_spi_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, frame, rx_stb;
  logic [7:0]  rx_data;
  logic [7:0]  tx8, tx16, wdata8, rdata8;
  logic [5:0]  addr8, addr16;
  logic [15:0] wdata16, rdata16;
  logic        we8, we16, hold8, hold16;

  logic [7:0]  mem8  [64];
  logic [15:0] mem16 [64];
  int   we8_cnt = 0, we16_cnt = 0;
  logic we8_prev = 1'b0, we16_prev = 1'b0, dbl_we = 1'b0, preloaded = 1'b0;
  int   checks = 0, fails = 0;
  int   base8, base16;

  assign rdata8  = mem8[addr8];
  assign rdata16 = mem16[addr16];

  spi_mem_bridge #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .frame_i(frame),
    .rx_data_i(rx_data), .rx_stb_i(rx_stb), .tx_data_o(tx8),
    .mem_addr_o(addr8), .mem_wdata_o(wdata8), .mem_we_o(we8),
    .mem_rdata_i(rdata8), .cpu_hold_o(hold8)
  );

  spi_mem_bridge #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .frame_i(frame),
    .rx_data_i(rx_data), .rx_stb_i(rx_stb), .tx_data_o(tx16),
    .mem_addr_o(addr16), .mem_wdata_o(wdata16), .mem_we_o(we16),
    .mem_rdata_i(rdata16), .cpu_hold_o(hold16)
  );

  // Memory models: capture write pulses mid-cycle and flag back-to-back pulses.
  always @(negedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 64; i++) begin
        mem8[i]  = 8'h00;
        mem16[i] = 16'h0000;
      end
      mem16[5]  = 16'hBEEF;
      mem16[6]  = 16'hCAFE;
      preloaded = 1'b1;
    end
    if (we8) begin
      mem8[addr8] = wdata8;
      we8_cnt++;
    end
    if (we16) begin
      mem16[addr16] = wdata16;
      we16_cnt++;
    end
    if ((we8 && we8_prev) || (we16 && we16_prev)) dbl_we = 1'b1;
    we8_prev  = we8;
    we16_prev = we16;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
    idle(3);
  endtask

  task automatic frame_on();
    @(negedge clk);
    frame = 1'b1;
    idle(1);
  endtask

  task automatic frame_off();
    @(negedge clk);
    frame = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; frame = 1'b0; rx_stb = 1'b0; rx_data = 8'h00;
    idle(3);
    checks++; if (tx8 !== 8'h00 || tx16 !== 8'h00) begin fails++; $display("FAIL reset_tx: got %h/%h exp 00", tx8, tx16); end
    checks++; if (addr8 !== 6'd0 || addr16 !== 6'd0) begin fails++; $display("FAIL reset_addr: got %h/%h exp 0", addr8, addr16); end
    checks++; if (wdata8 !== 8'h00 || wdata16 !== 16'h0000 || we8 !== 1'b0 || we16 !== 1'b0) begin
      fails++; $display("FAIL reset_wr: got %h/%h we %b/%b exp 0", wdata8, wdata16, we8, we16); end
    checks++; if (hold16 !== 1'b0) begin fails++; $display("FAIL reset_hold: got %b exp 0", hold16); end
    rst = 1'b0;
    idle(1);
    enable = 1'b1;
    idle(2);
    checks++; if (hold8 !== 1'b1) begin fails++; $display("FAIL hold_en: got %b exp 1", hold8); end
  endtask

  task automatic test_write8();
    base8 = we8_cnt;
    frame_on();
    send(8'h01); send(8'h00); send(8'hAA); send(8'h55);
    frame_off();
    checks++; if (we8_cnt - base8 !== 2) begin fails++; $display("FAIL w8_pulses: got %0d exp 2", we8_cnt - base8); end
    checks++; if (mem8[0] !== 8'hAA || mem8[1] !== 8'h55) begin fails++; $display("FAIL w8_data: got %h %h exp AA 55", mem8[0], mem8[1]); end
    checks++; if (addr8 !== 6'd2) begin fails++; $display("FAIL w8_addr: got %0d exp 2", addr8); end
  endtask

  task automatic test_write16_wrap();
    base16 = we16_cnt;
    frame_on();
    send(8'h01); send(8'h3F); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    frame_off();
    checks++; if (we16_cnt - base16 !== 2) begin fails++; $display("FAIL w16_pulses: got %0d exp 2", we16_cnt - base16); end
    checks++; if (mem16[63] !== 16'h1234) begin fails++; $display("FAIL w16_3f: got %h exp 1234", mem16[63]); end
    checks++; if (mem16[0] !== 16'h5678) begin fails++; $display("FAIL w16_00: got %h exp 5678", mem16[0]); end
    checks++; if (addr16 !== 6'd1) begin fails++; $display("FAIL w16_addr: got %0d exp 1", addr16); end
  endtask

  task automatic test_read16();
    base16 = we16_cnt;
    frame_on();
    send(8'h02); send(8'h05);
    checks++; if (tx16 !== 8'hBE) begin fails++; $display("FAIL rd_b0: got %h exp BE", tx16); end
    send(8'h00);
    checks++; if (tx16 !== 8'hEF) begin fails++; $display("FAIL rd_b1: got %h exp EF", tx16); end
    send(8'h00);
    checks++; if (tx16 !== 8'hCA) begin fails++; $display("FAIL rd_b2: got %h exp CA", tx16); end
    checks++; if (addr16 !== 6'd6) begin fails++; $display("FAIL rd_addr: got %0d exp 6", addr16); end
    send(8'h00);
    checks++; if (tx16 !== 8'hFE) begin fails++; $display("FAIL rd_b3: got %h exp FE", tx16); end
    frame_off();
    checks++; if (we16_cnt - base16 !== 0) begin fails++; $display("FAIL rd_nowe: got %0d exp 0", we16_cnt - base16); end
  endtask

  task automatic test_status();
    // wr_cnt=3 (one AA55 word from the 8-bit vectors plus two), wrap set
    frame_on(); send(8'h05);
    checks++; if (tx16 !== 8'h43) begin fails++; $display("FAIL st_first: got %h exp 43", tx16); end
    send(8'h00); frame_off();
    base16 = we16_cnt;
    frame_on(); send(8'h7E); send(8'h11); send(8'h22); send(8'h33); frame_off();
    checks++; if (we16_cnt - base16 !== 0) begin fails++; $display("FAIL badop_nowe: got %0d exp 0", we16_cnt - base16); end
    frame_on(); send(8'h05);
    checks++; if (tx16 !== 8'h80) begin fails++; $display("FAIL st_badop: got %h exp 80", tx16); end
    send(8'h00); frame_off();
    frame_on(); send(8'h05);
    checks++; if (tx16 !== 8'h00) begin fails++; $display("FAIL st_clear: got %h exp 00", tx16); end
    send(8'h00); frame_off();
  endtask

  task automatic test_partial();
    base16 = we16_cnt;
    frame_on();
    send(8'h01); send(8'h2A); send(8'h11);
    @(negedge clk);
    frame = 1'b0; rx_data = 8'h22; rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
    idle(4);
    checks++; if (we16_cnt - base16 !== 0) begin fails++; $display("FAIL partial_nowe: got %0d exp 0", we16_cnt - base16); end
    checks++; if (addr16 !== 6'h2A) begin fails++; $display("FAIL partial_addr: got %h exp 2a", addr16); end
  endtask

  task automatic test_reset_mid();
    base16 = we16_cnt;
    frame_on();
    send(8'h01); send(8'h10); send(8'hAB);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx16 !== 8'h00 || addr16 !== 6'd0 || wdata16 !== 16'h0000 || we16 !== 1'b0) begin
      fails++; $display("FAIL rst_mid: got tx %h addr %h wd %h we %b exp 0", tx16, addr16, wdata16, we16); end
    rst = 1'b0; frame = 1'b0;
    idle(3);
    checks++; if (we16_cnt - base16 !== 0) begin fails++; $display("FAIL rst_nowe: got %0d exp 0", we16_cnt - base16); end
  endtask

  task automatic test_enable();
    frame_on();
    send(8'h01); send(8'h20);
    checks++; if (addr16 !== 6'h20) begin fails++; $display("FAIL en_addr: got %h exp 20", addr16); end
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    checks++; if (hold16 !== 1'b0 || tx16 !== 8'h00) begin fails++; $display("FAIL en_off: got hold %b tx %h exp 0 00", hold16, tx16); end
    base16 = we16_cnt;
    send(8'h33);
    @(negedge clk); enable = 1'b1;
    idle(2);
    checks++; if (addr16 !== 6'd0) begin fails++; $display("FAIL en_clr: got %h exp 0", addr16); end
    send(8'h01); send(8'h05); send(8'h77); send(8'h88);
    frame_off();
    checks++; if (mem16[5] !== 16'h7788) begin fails++; $display("FAIL en_write: got %h exp 7788", mem16[5]); end
    checks++; if (we16_cnt - base16 !== 1 || addr16 !== 6'd6) begin
      fails++; $display("FAIL en_cnt: got %0d addr %0d exp 1 6", we16_cnt - base16, addr16); end
    checks++; if (dbl_we !== 1'b0) begin fails++; $display("FAIL we_double: got %b exp 0", dbl_we); end
  endtask

  initial begin
    test_reset();
    test_write8();
    test_write16_wrap();
    test_read16();
    test_status();
    test_partial();
    test_reset_mid();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
